// File: rtl/regfile_pkg.sv
// Shared widths, types and constants for the register file slice.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_sb_if.sv
// Read, writeback and issue bundle between the core and regfile_sb.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = 2
);

  localparam int NREGS = 2**ADDR_W;

  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  iss_en;
  logic [ADDR_W-1:0]     iss_addr;
  logic                  iss_ok;
  logic [NREGS-1:0]      busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data,
    output iss_en, iss_addr,
    input  rd_data, rd_busy, iss_ok, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data,
    input  iss_en, iss_addr,
    output rd_data, rd_busy, iss_ok, busy_vec
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Write-pending scoreboard: one busy bit per register.
// Issue sets, writeback clears; issue wins on a same-register collision.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_en,
  input  logic [ADDR_W-1:0]    iss_addr,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  output logic                 iss_ok,
  output logic [2**ADDR_W-1:0] busy_vec
);

  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);

  logic [NREGS-1:0] busy_nxt;
  logic             wr_hit;

  assign wr_hit = wr_en && (wr_addr == iss_addr);
  assign iss_ok = iss_en && (!busy_vec[iss_addr] || wr_hit);

  always_comb begin
    busy_nxt = busy_vec;
    if (wr_en) busy_nxt[wr_addr] = 1'b0;
    if (iss_ok) busy_nxt[iss_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[ZA] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_vec <= '0;
    else busy_vec <= busy_nxt;
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with integrated write-pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to readers.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input logic        clk,
  input logic        rst,
  regfile_sb_if.slave bus
);

  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0]     regs [NREGS];
  logic [NREGS-1:0]      busy;
  logic                  iss_ok;
  logic                  wr_drop;
  logic [NRD*DATA_W-1:0] rdata;
  logic [NRD-1:0]        rbusy;

  assign wr_drop = (ZERO_REG != 0) && (bus.wr_addr == ZA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (bus.wr_en && !wr_drop) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .iss_ok   (iss_ok),
    .busy_vec (busy)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              zero;
    assign a    = bus.rd_addr[i*ADDR_W +: ADDR_W];
    assign zero = (ZERO_REG != 0) && (a == ZA);
`ifdef REGFILE_BYPASS_EN
    logic hit;
    // Forwarding is suppressed under reset so readers see zeros.
    assign hit = bus.wr_en && !rst && (bus.wr_addr == a);
    assign rdata[i*DATA_W +: DATA_W] =
      zero ? '0 : (hit ? bus.wr_data : regs[a]);
    assign rbusy[i] = !zero && !hit && busy[a];
`else
    assign rdata[i*DATA_W +: DATA_W] = zero ? '0 : regs[a];
    assign rbusy[i] = !zero && busy[a];
`endif
  end

  assign bus.rd_data  = rdata;
  assign bus.rd_busy  = rbusy;
  assign bus.iss_ok   = iss_ok;
  assign bus.busy_vec = busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (NRD=4, DATA_W=64, ZERO_REG=1).
module tb_regfile_sb;

  localparam int DW  = 64;
  localparam int AW  = 5;
  localparam int NRD = 4;
  localparam int NR  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) bus ();

  regfile_sb #(
    .DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .ZERO_REG(1)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];

  logic          c_we, c_ie;
  logic [AW-1:0] c_wa, c_ia;
  logic [DW-1:0] c_wd;
  logic [19:0]   c_ra;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int r = 0; r < NR; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  function automatic bit m_iss_ok();
    return c_ie && (c_ia == 0 || !m_busy[c_ia] ||
                    (c_we && c_wa == c_ia));
  endfunction

  task automatic model_check(input string tag);
    logic [NR-1:0] bv;
    logic [AW-1:0] a;
    logic [DW-1:0] ed;
    bit            eb;
    for (int p = 0; p < NRD; p++) begin
      a  = c_ra[p*AW +: AW];
      ed = m_regs[a];
      eb = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (c_we && !rst && c_wa == a) begin
        ed = c_wd;
        eb = 1'b0;
      end
`endif
      if (a == 0) begin
        ed = '0;
        eb = 1'b0;
      end
      chk($sformatf("%s_rd%0d_a%0d", tag, p, a),
          bus.rd_data[p*DW +: DW], ed);
      chk($sformatf("%s_busy%0d_a%0d", tag, p, a),
          64'(bus.rd_busy[p]), 64'(eb));
    end
    for (int r = 0; r < NR; r++) bv[r] = m_busy[r];
    chk({tag, "_busy_vec"}, 64'(bus.busy_vec), 64'(bv));
    chk({tag, "_iss_ok"}, 64'(bus.iss_ok),
        64'(rst ? 1'b0 : m_iss_ok()));
  endtask

  task automatic drive(input string tag,
                       input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd,
                       input logic ie, input logic [AW-1:0] ia,
                       input logic [19:0] ra);
    c_we = we; c_wa = wa; c_wd = wd;
    c_ie = ie; c_ia = ia; c_ra = ra;
    bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
    bus.iss_en = ie; bus.iss_addr = ia; bus.rd_addr = ra;
    #2;
    model_check(tag);
  endtask

  task automatic tick();
    bit ok;
    @(posedge clk);
    if (!rst) begin
      ok = m_iss_ok();
      if (c_we && c_wa != 0) begin
        m_regs[c_wa] = c_wd;
        m_busy[c_wa] = 1'b0;
      end
      if (ok && c_ia != 0) m_busy[c_ia] = 1'b1;
    end
    #1;
  endtask

  function automatic logic [19:0] ra4(input int a0, a1, a2, a3);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  initial begin
    logic [19:0] ra;
    m_reset();
    c_we = 0; c_ie = 0; c_wa = 0; c_ia = 0;
    c_wd = '0; c_ra = '0;
    bus.wr_en = 0; bus.iss_en = 0; bus.wr_addr = '0;
    bus.iss_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
    #2;
    chk("rst_busy_vec", 64'(bus.busy_vec), 64'd0);
    chk("rst_rd_busy", 64'(bus.rd_busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset mid-operation
    for (int r = 1; r < 5; r++) begin
      drive("fill", 1, 5'(r), 64'h100 + 64'(r), 1, 5'(r + 9), ra4(r, 0, 0, 0));
      tick();
    end
    drive("prerst", 1, 5'd12, 64'hCAFE, 0, 0, ra4(1, 2, 3, 4));
    chk("prerst_r2", bus.rd_data[DW +: DW], 64'h102);
    rst = 1'b1;
    m_reset();
    #1;
    chk("rst_mid_rd0", bus.rd_data[0 +: DW], 64'd0);
    chk("rst_mid_rd3", bus.rd_data[3*DW +: DW], 64'd0);
    chk("rst_mid_busy_vec", 64'(bus.busy_vec), 64'd0);
    model_check("rst_mid");
    tick();
    rst = 1'b0;
    drive("post_rst", 0, 0, 0, 0, 0, ra4(10, 11, 12, 1));
    chk("post_rst_r12", bus.rd_data[2*DW +: DW], 64'd0);
    chk("post_rst_rd_busy", 64'(bus.rd_busy), 64'd0);
    tick();

    // Plain write and r0 hard-wiring
    drive("w5", 1, 5'd5, 64'hDEADBEEF, 0, 0, ra4(0, 0, 0, 0));
    tick();
    drive("r5", 1, 5'd0, 64'h1234, 0, 0, ra4(5, 5, 5, 5));
    chk("r5_p0", bus.rd_data[0 +: DW], 64'hDEADBEEF);
    chk("r5_p1", bus.rd_data[DW +: DW], 64'hDEADBEEF);
    tick();
    drive("r0", 0, 0, 0, 1, 5'd0, ra4(0, 5, 0, 0));
    chk("r0_data", bus.rd_data[0 +: DW], 64'd0);
    chk("iss_r0_ok", 64'(bus.iss_ok), 64'd1);
    tick();
    chk("iss_r0_not_busy", 64'(bus.busy_vec[0]), 64'd0);

    // Issue, refused WAW, release on write
    drive("iss7", 0, 0, 0, 1, 5'd7, ra4(7, 0, 0, 0));
    chk("iss7_ok", 64'(bus.iss_ok), 64'd1);
    tick();
    chk("iss7_busy", 64'(bus.busy_vec[7]), 64'd1);
    drive("reiss7", 0, 0, 0, 1, 5'd7, ra4(7, 0, 0, 0));
    chk("reiss7_ok", 64'(bus.iss_ok), 64'd0);
    tick();
    drive("w7", 1, 5'd7, 64'h55, 0, 0, ra4(0, 0, 0, 0));
    tick();
    drive("r7", 0, 0, 0, 0, 0, ra4(7, 0, 0, 7));
    chk("r7_busy_clr", 64'(bus.busy_vec[7]), 64'd0);
    chk("r7_data", bus.rd_data[0 +: DW], 64'h55);
    tick();

    // Same-cycle writeback and issue to a pending register
    drive("iss9", 0, 0, 0, 1, 5'd9, ra4(0, 0, 0, 0));
    tick();
    drive("wi9", 1, 5'd9, 64'hAA, 1, 5'd9, ra4(9, 0, 0, 0));
    chk("wi9_ok", 64'(bus.iss_ok), 64'd1);
    tick();
    drive("r9", 0, 0, 0, 0, 0, ra4(9, 9, 0, 0));
    chk("r9_data", bus.rd_data[DW +: DW], 64'hAA);
    chk("r9_busy", 64'(bus.busy_vec[9]), 64'd1);
    tick();

    // Read of a register during its own writeback
    drive("w3", 1, 5'd3, 64'h11, 0, 0, ra4(0, 0, 0, 0));
    tick();
    drive("iss3", 0, 0, 0, 1, 5'd3, ra4(0, 0, 0, 0));
    tick();
    drive("byp3", 1, 5'd3, 64'h77, 0, 0, ra4(3, 3, 0, 0));
`ifdef REGFILE_BYPASS_EN
    chk("byp3_data", bus.rd_data[0 +: DW], 64'h77);
    chk("byp3_busy", 64'(bus.rd_busy[0]), 64'd0);
`else
    chk("byp3_data", bus.rd_data[0 +: DW], 64'h11);
    chk("byp3_busy", 64'(bus.rd_busy[0]), 64'd1);
`endif
    tick();
    drive("aft3", 0, 0, 0, 0, 0, ra4(3, 0, 0, 0));
    chk("aft3_data", bus.rd_data[0 +: DW], 64'h77);
    chk("aft3_busy", 64'(bus.rd_busy[0]), 64'd0);
    tick();

    // Random traffic against the reference model
    for (int n = 0; n < 10000; n++) begin
      logic          we, ie;
      logic [AW-1:0] wa, ia;
      logic [DW-1:0] wd;
      we = 1'($urandom_range(0, 1));
      ie = 1'($urandom_range(0, 1));
      wa = $urandom_range(0, 1) ? 5'($urandom_range(0, 7))
                                : 5'($urandom_range(0, 31));
      ia = $urandom_range(0, 1) ? 5'($urandom_range(0, 7))
                                : 5'($urandom_range(0, 31));
      wd = {$urandom, $urandom};
      for (int p = 0; p < NRD; p++) begin
        if ($urandom_range(0, 2) == 0) ra[p*AW +: AW] = wa;
        else ra[p*AW +: AW] = 5'($urandom_range(0, 15));
      end
      drive("rnd", we, wa, wd, ie, ia, ra);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
